// File: rtl/ivport_fire_sched.sv
`timescale 1ns/1ps
// ivport_fire_sched
//   Egress scheduler downstream of the ivport rreq/rresp/wreq queue buffer.
//   Each granted IPG slot pops exactly one queue (weighted round-robin
//   RRESP -> RREQ -> WREQ) and the popped head word is registered onto the
//   egress data path one cycle later. A downstream credit pool gates grants.
//
//   Ports:
//     clk, rst (async, active-low)
//     sched_en      global enable; low holds all arbitration/credit state
//     slot_avail    egress IPG slot strobe
//     *_empty       registered empty flags of the three queues
//     fire_ipg_data show-ahead head word of the selected queue
//     credit_ret    one-cycle credit return pulse
//     fire_en       combinational pop strobe
//     fire_type_sel combinational queue select (0 RREQ, 1 RRESP, 2 WREQ, 3 none)
//     out_data/out_valid/out_type  registered egress word, valid and class
//     credit_cnt    current credit count
//
//   Optional build macro IVPORT_FIRE_SCHED_STATS_EN adds per-class grant
//   counters (stat_rreq, stat_rresp, stat_wreq) and a credit-stall counter
//   (stat_stall), all 32-bit wrapping.
module ivport_fire_sched #(
    parameter int DATA_WIDTH = 64,
    parameter int W_RRESP    = 4,
    parameter int W_RREQ     = 2,
    parameter int W_WREQ     = 2,
    parameter int CREDITS    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sched_en,
    input  logic                          slot_avail,
    input  logic                          rreq_empty,
    input  logic                          rresp_empty,
    input  logic                          wreq_empty,
    input  logic [DATA_WIDTH-1:0]         fire_ipg_data,
    input  logic                          credit_ret,
    output logic                          fire_en,
    output logic [1:0]                    fire_type_sel,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic [1:0]                    out_type,
`ifdef IVPORT_FIRE_SCHED_STATS_EN
    output logic [31:0]                   stat_rreq,
    output logic [31:0]                   stat_rresp,
    output logic [31:0]                   stat_wreq,
    output logic [31:0]                   stat_stall,
`endif
    output logic [$clog2(CREDITS+1)-1:0]  credit_cnt
);

    typedef enum logic [1:0] {
        CLS_RREQ  = 2'd0,
        CLS_RRESP = 2'd1,
        CLS_WREQ  = 2'd2,
        CLS_NONE  = 2'd3
    } cls_t;

    localparam int CW      = $clog2(CREDITS + 1);
    // A zero weight would starve its class forever; treat it as one grant per turn.
    localparam int WR_EFF  = (W_RREQ  < 1) ? 1 : W_RREQ;
    localparam int WP_EFF  = (W_RRESP < 1) ? 1 : W_RRESP;
    localparam int WW_EFF  = (W_WREQ  < 1) ? 1 : W_WREQ;
    localparam int WMAX    = (WR_EFF > WP_EFF) ? ((WR_EFF > WW_EFF) ? WR_EFF : WW_EFF)
                                               : ((WP_EFF > WW_EFF) ? WP_EFF : WW_EFF);
    localparam int BW      = $clog2(WMAX + 1);

    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
    localparam logic [BW-1:0] BURST_ZERO = BW'(0);
    localparam logic [CW-1:0] CRED_MAX   = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE   = CW'(1);
    localparam logic [CW-1:0] CRED_ZERO  = CW'(0);

    // Non-empty test for one class given the three empty flags.
    function automatic logic cls_ne(input cls_t c, input logic e_rreq,
                                    input logic e_rresp, input logic e_wreq);
        logic r;
        case (c)
            CLS_RREQ:  r = ~e_rreq;
            CLS_RRESP: r = ~e_rresp;
            CLS_WREQ:  r = ~e_wreq;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Successor in rotation order RRESP -> RREQ -> WREQ -> RRESP.
    function automatic cls_t cls_next(input cls_t c);
        cls_t r;
        case (c)
            CLS_RRESP: r = CLS_RREQ;
            CLS_RREQ:  r = CLS_WREQ;
            CLS_WREQ:  r = CLS_RRESP;
            default:   r = CLS_RRESP;
        endcase
        return r;
    endfunction

    // Per-turn grant limit of a class.
    function automatic logic [BW-1:0] cls_weight(input cls_t c);
        logic [BW-1:0] r;
        case (c)
            CLS_RREQ:  r = BW'(WR_EFF);
            CLS_RRESP: r = BW'(WP_EFF);
            CLS_WREQ:  r = BW'(WW_EFF);
            default:   r = BURST_ONE;
        endcase
        return r;
    endfunction

    cls_t                  cur_r;
    logic [BW-1:0]         burst_r;
    logic [CW-1:0]         credit_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_valid_r;
    logic [1:0]            out_type_r;

    logic                  any_ne_s;
    logic                  grant_s;
    cls_t                  sel_s;
    cls_t                  cur_nxt_s;
    cls_t                  n1_s;
    cls_t                  n2_s;
    logic [BW-1:0]         burst_nxt_s;

    assign any_ne_s = ~rreq_empty | ~rresp_empty | ~wreq_empty;
    // rst is folded in so the strobe is forced off while reset is held.
    assign grant_s  = rst & sched_en & slot_avail & (credit_r != CRED_ZERO) & any_ne_s;

    // Weighted round-robin choice of the class to serve and the next cur/burst.
    always_comb begin
        sel_s       = cur_r;
        cur_nxt_s   = cur_r;
        burst_nxt_s = burst_r;
        n1_s        = cls_next(cur_r);
        n2_s        = cls_next(n1_s);
        if (cls_ne(cur_r, rreq_empty, rresp_empty, wreq_empty) &&
            (burst_r < cls_weight(cur_r))) begin
            sel_s       = cur_r;
            burst_nxt_s = burst_r + BURST_ONE;
        end else if (cls_ne(n1_s, rreq_empty, rresp_empty, wreq_empty)) begin
            sel_s       = n1_s;
            cur_nxt_s   = n1_s;
            burst_nxt_s = BURST_ONE;
        end else if (cls_ne(n2_s, rreq_empty, rresp_empty, wreq_empty)) begin
            sel_s       = n2_s;
            cur_nxt_s   = n2_s;
            burst_nxt_s = BURST_ONE;
        end else begin
            // Search wrapped to cur: it is the only candidate, start a fresh turn.
            sel_s       = cur_r;
            cur_nxt_s   = cur_r;
            burst_nxt_s = BURST_ONE;
        end
    end

    assign fire_en       = grant_s;
    assign fire_type_sel = grant_s ? sel_s : CLS_NONE;

    // Arbitration state advances only on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_r   <= CLS_RRESP;
            burst_r <= BURST_ZERO;
        end else if (grant_s) begin
            cur_r   <= cur_nxt_s;
            burst_r <= burst_nxt_s;
        end else begin
            cur_r   <= cur_r;
            burst_r <= burst_r;
        end
    end

    // Credit pool: -1 per grant, +1 per return, saturating at CREDITS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_r <= CRED_MAX;
        end else begin
            case ({grant_s, credit_ret})
                2'b10:   credit_r <= credit_r - CRED_ONE;
                2'b01:   credit_r <= (credit_r < CRED_MAX) ? credit_r + CRED_ONE : credit_r;
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Egress register: captures the show-ahead head word of the granted queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_type_r  <= CLS_NONE;
        end else if (grant_s) begin
            out_data_r  <= fire_ipg_data;
            out_valid_r <= 1'b1;
            out_type_r  <= sel_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign out_type   = out_type_r;
    assign credit_cnt = credit_r;

`ifdef IVPORT_FIRE_SCHED_STATS_EN
    logic [31:0] stat_rreq_r;
    logic [31:0] stat_rresp_r;
    logic [31:0] stat_wreq_r;
    logic [31:0] stat_stall_r;

    // Per-class grant counters and credit-starvation stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rreq_r  <= 32'd0;
            stat_rresp_r <= 32'd0;
            stat_wreq_r  <= 32'd0;
            stat_stall_r <= 32'd0;
        end else begin
            if (grant_s && (sel_s == CLS_RREQ))  stat_rreq_r  <= stat_rreq_r  + 32'd1;
            if (grant_s && (sel_s == CLS_RRESP)) stat_rresp_r <= stat_rresp_r + 32'd1;
            if (grant_s && (sel_s == CLS_WREQ))  stat_wreq_r  <= stat_wreq_r  + 32'd1;
            if (slot_avail && sched_en && any_ne_s && (credit_r == CRED_ZERO))
                stat_stall_r <= stat_stall_r + 32'd1;
        end
    end

    assign stat_rreq  = stat_rreq_r;
    assign stat_rresp = stat_rresp_r;
    assign stat_wreq  = stat_wreq_r;
    assign stat_stall = stat_stall_r;
`endif

endmodule

// File: tb/tb_ivport_fire_sched.sv
`timescale 1ns/1ps
// Testbench for ivport_fire_sched: queue models feed the empty flags and the
// show-ahead data, a scoreboard holds the word expected on the egress port
// one cycle after each observed grant, and directed scenarios check the
// weighted round-robin order, credit handling and reset behaviour.
module tb_ivport_fire_sched;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          sched_en;
    logic          slot_avail;
    logic          rreq_empty;
    logic          rresp_empty;
    logic          wreq_empty;
    logic [DW-1:0] fire_ipg_data;
    logic          credit_ret;
    logic          fire_en;
    logic [1:0]    fire_type_sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [1:0]    out_type;
    logic [3:0]    credit_cnt;
`ifdef IVPORT_FIRE_SCHED_STATS_EN
    logic [31:0]   stat_rreq, stat_rresp, stat_wreq, stat_stall;
`endif

    always #5 clk = ~clk;

    ivport_fire_sched #(
        .DATA_WIDTH(DW), .W_RRESP(4), .W_RREQ(2), .W_WREQ(2), .CREDITS(8)
    ) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en), .slot_avail(slot_avail),
        .rreq_empty(rreq_empty), .rresp_empty(rresp_empty), .wreq_empty(wreq_empty),
        .fire_ipg_data(fire_ipg_data), .credit_ret(credit_ret),
        .fire_en(fire_en), .fire_type_sel(fire_type_sel),
        .out_data(out_data), .out_valid(out_valid), .out_type(out_type),
`ifdef IVPORT_FIRE_SCHED_STATS_EN
        .stat_rreq(stat_rreq), .stat_rresp(stat_rresp), .stat_wreq(stat_wreq),
        .stat_stall(stat_stall),
`endif
        .credit_cnt(credit_cnt)
    );

    typedef struct packed {
        logic [1:0]    t;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] q_rreq[$];
    logic [DW-1:0] q_rresp[$];
    logic [DW-1:0] q_wreq[$];
    logic [1:0]    sel_log[$];
    int            n_err = 0;
    int            n_chk = 0;
    int            g_cnt = 0;
    logic          echo_en = 1'b0;
    logic          last_gnt;
    logic          last_slot;
    logic [31:0]   word_id = 32'd1;
    logic [1:0]    exp_seq [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1};

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] head(input logic [1:0] s);
        logic [DW-1:0] r;
        r = '0;
        case (s)
            2'd0:    if (q_rreq.size()  > 0) r = q_rreq[0];
            2'd1:    if (q_rresp.size() > 0) r = q_rresp[0];
            2'd2:    if (q_wreq.size()  > 0) r = q_wreq[0];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_empty(input logic [1:0] s);
        logic r;
        case (s)
            2'd0:    r = (q_rreq.size()  == 0);
            2'd1:    r = (q_rresp.size() == 0);
            2'd2:    r = (q_wreq.size()  == 0);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    task automatic set_empties();
        rreq_empty  = is_empty(2'd0);
        rresp_empty = is_empty(2'd1);
        wreq_empty  = is_empty(2'd2);
    endtask

    task automatic push_words(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = {30'h0, s, word_id};
            word_id = word_id + 32'd1;
            case (s)
                2'd0:    q_rreq.push_back(w);
                2'd1:    q_rresp.push_back(w);
                default: q_wreq.push_back(w);
            endcase
        end
        set_empties();
    endtask

    task automatic pop_word(input logic [1:0] s);
        case (s)
            2'd0:    if (q_rreq.size()  > 0) void'(q_rreq.pop_front());
            2'd1:    if (q_rresp.size() > 0) void'(q_rresp.pop_front());
            2'd2:    if (q_wreq.size()  > 0) void'(q_wreq.pop_front());
            default: ;
        endcase
    endtask

    task automatic flush_all();
        q_rreq.delete();
        q_rresp.delete();
        q_wreq.delete();
        set_empties();
    endtask

    // One clock: present head data, compare egress against the scoreboard and
    // record any grant at the falling edge, then pop the queue model after the edge.
    task automatic tick();
        logic       gnt;
        logic [1:0] s;
        logic       ov;
        exp_t       e;
        #1;
        fire_ipg_data = head(fire_type_sel);
        @(negedge clk);
        gnt       = fire_en;
        s         = fire_type_sel;
        ov        = out_valid;
        last_gnt  = gnt;
        last_slot = slot_avail;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("out_valid", 64'(ov), 64'(1'b1));
            check_val("out_type", 64'(out_type), 64'(e.t));
            check_val("out_data", out_data, e.d);
        end else begin
            check_val("out_valid_idle", 64'(ov), 64'(1'b0));
        end
        if (gnt) begin
            check_val("fire_nonempty", 64'(is_empty(s)), 64'(1'b0));
            e.t = s;
            e.d = head(s);
            exp_q.push_back(e);
            sel_log.push_back(s);
            g_cnt++;
        end
        @(posedge clk);
        #1;
        if (gnt) pop_word(s);
        set_empties();
        if (echo_en) credit_ret = ov;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; sched_en = 1'b1; slot_avail = 1'b1; credit_ret = 1'b0;
        fire_ipg_data = '0;
        flush_all();
        push_words(2'd1, 12);
        push_words(2'd0, 12);
        push_words(2'd2, 12);
        #12;
        // Reset state with all queues non-empty and a slot offered.
        check_val("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check_val("rst_out_type", 64'(out_type), 64'(2'd3));
        check_val("rst_out_data", out_data, 64'd0);
        check_val("rst_credit", 64'(credit_cnt), 64'(4'd8));
        check_val("rst_fire_en", 64'(fire_en), 64'(1'b0));
        check_val("rst_sel", 64'(fire_type_sel), 64'(2'd3));

        // Weighted round-robin with credits echoed back.
        @(posedge clk); #1;
        echo_en = 1'b1;
        rst = 1'b1;
        sel_log.delete();
        repeat (10) tick();
        check_val("wrr_count", 64'(sel_log.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            if (i < sel_log.size()) check_val("wrr_seq", 64'(sel_log[i]), 64'(exp_seq[i]));
        slot_avail = 1'b0;
        flush_all();
        repeat (4) tick();
        check_val("wrr_drained", 64'(exp_q.size()), 64'd0);
        check_val("wrr_credit", 64'(credit_cnt), 64'(4'd8));

        // Only wreq holds five words.
        push_words(2'd2, 5);
        slot_avail = 1'b1;
        sel_log.delete();
        g_cnt = 0;
        repeat (7) tick();
        check_val("wreq_grants", 64'(g_cnt), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < sel_log.size()) check_val("wreq_sel", 64'(sel_log[i]), 64'(2'd2));
        check_val("wreq_idle_sel", 64'(fire_type_sel), 64'(2'd3));
        slot_avail = 1'b0;
        repeat (3) tick();
        check_val("wreq_credit", 64'(credit_cnt), 64'(4'd8));

        // Credit exhaustion and a single returned credit.
        echo_en = 1'b0;
        credit_ret = 1'b0;
        push_words(2'd1, 10);
        slot_avail = 1'b1;
        g_cnt = 0;
        repeat (11) tick();
        check_val("exhaust_grants", 64'(g_cnt), 64'd8);
        check_val("exhaust_credit", 64'(credit_cnt), 64'(4'd0));
        credit_ret = 1'b1;
        g_cnt = 0;
        tick();
        credit_ret = 1'b0;
        check_val("ret_cycle_blocked", 64'(g_cnt), 64'd0);
        check_val("ret_credit", 64'(credit_cnt), 64'(4'd1));
        repeat (3) tick();
        check_val("ret_one_grant", 64'(g_cnt), 64'd1);
        check_val("ret_credit_used", 64'(credit_cnt), 64'(4'd0));
        slot_avail = 1'b0;
        flush_all();
        credit_ret = 1'b1;
        repeat (9) tick();
        credit_ret = 1'b0;
        check_val("credit_saturate", 64'(credit_cnt), 64'(4'd8));

        // Grant and return in the same cycle at credit_cnt=3.
        push_words(2'd0, 10);
        slot_avail = 1'b1;
        repeat (5) tick();
        check_val("credit_three", 64'(credit_cnt), 64'(4'd3));
        credit_ret = 1'b1;
        g_cnt = 0;
        tick();
        credit_ret = 1'b0;
        check_val("simul_grant", 64'(g_cnt), 64'd1);
        check_val("simul_credit", 64'(credit_cnt), 64'(4'd3));
        slot_avail = 1'b0;
        credit_ret = 1'b1;
        repeat (5) tick();
        credit_ret = 1'b0;
        check_val("credit_refill", 64'(credit_cnt), 64'(4'd8));

        // slot_avail toggling with rreq non-empty.
        echo_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            slot_avail = ((i % 2) == 0);
            tick();
            check_val("slot_fire", 64'(last_gnt), 64'(last_slot));
        end
        slot_avail = 1'b0;
        flush_all();
        repeat (4) tick();
        check_val("toggle_credit", 64'(credit_cnt), 64'(4'd8));

        // Reset asserted mid-burst while out_valid is high.
        echo_en = 1'b0;
        credit_ret = 1'b0;
        push_words(2'd1, 6);
        slot_avail = 1'b1;
        tick();
        tick();
        check_val("pre_rst_valid", 64'(out_valid), 64'(1'b1));
        rst = 1'b0;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        check_val("midrst_fire_en", 64'(fire_en), 64'(1'b0));
        check_val("midrst_sel", 64'(fire_type_sel), 64'(2'd3));
        check_val("midrst_credit", 64'(credit_cnt), 64'(4'd8));
        exp_q.delete();
        tick();
        tick();
        push_words(2'd0, 3);
        push_words(2'd2, 3);
        rst = 1'b1;
        sel_log.delete();
        tick();
        check_val("restart_count", 64'(sel_log.size()), 64'd1);
        if (sel_log.size() > 0) check_val("restart_sel", 64'(sel_log[0]), 64'(2'd1));
        slot_avail = 1'b0;
        flush_all();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ivport_fire_sched.md
Name: ivport_fire_sched

Overview:
- Egress scheduler sitting directly downstream of the ivport three-queue buffer (rreq / rresp / wreq).
- Watches the queue empty flags plus an egress IPG slot strobe and a downstream credit pool.
- Drives fire_en/fire_type_sel to pop exactly one queue per granted slot, then registers the popped word onto the egress IPG data path.
- Arbitration is weighted round-robin, so read responses and requests cannot be starved by write bursts.

Parameters:
- DATA_WIDTH, 64, IPG data word width.
- W_RRESP, 4, max consecutive grants to the rresp queue per round.
- W_RREQ, 2, max consecutive grants to the rreq queue per round.
- W_WREQ, 2, max consecutive grants to the wreq queue per round.
- CREDITS, 8, downstream buffer credits available after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- sched_en  input  1  global enable; low = no firing, state held.
- slot_avail  input  1  egress IPG slot available this cycle.
- rreq_empty  input  1  rreq queue empty.
- rresp_empty  input  1  rresp queue empty.
- wreq_empty  input  1  wreq queue empty.
- fire_ipg_data  input  DATA_WIDTH  head word of the selected queue (show-ahead).
- credit_ret  input  1  one-cycle pulse returning one downstream credit.
- fire_en  output  1  pop strobe to ivport, combinational.
- fire_type_sel  output  2  queue select: 0=RREQ, 1=RRESP, 2=WREQ, 3=DISABLE.
- out_data  output  DATA_WIDTH  registered egress word.
- out_valid  output  1  out_data valid, one cycle per fire.
- out_type  output  2  class of out_data, same encoding.
- credit_cnt  output  $clog2(CREDITS+1)  current credits.

Behaviour:
- Reset (rst=0, async) values:
  - out_data=0, out_valid=0, out_type=3.
  - credit_cnt=CREDITS.
  - cur=RRESP, burst=0.
  - fire_en=0 and fire_type_sel=3 while rst is low.
  - Mid-operation reset drops out_valid immediately; any in-flight grant is discarded.
- Grant condition in cycle t: sched_en & slot_avail & (credit_cnt!=0) & at least one queue non-empty.
  - When the condition holds: fire_en=1 and fire_type_sel=granted class, both in cycle t.
  - Otherwise: fire_en=0 and fire_type_sel=3.
- Latency:
  - fire_ipg_data is sampled at the end of t.
  - out_data/out_type update and out_valid=1 in t+1, for exactly one cycle per grant.
  - Back-to-back grants give continuous out_valid.
- Arbitration:
  - Rotation order: RRESP -> RREQ -> WREQ -> RRESP.
  - Registered state: cur (class) and burst (grants so far to cur in this turn).
  - If cur is non-empty and burst < W_cur, grant cur and increment burst.
  - Otherwise grant the first non-empty class after cur in rotation order, set cur to it and burst=1.
  - If that search wraps back to cur (the only non-empty class), grant cur and set burst=1.
  - A weight parameter of 0 is treated as 1.
  - No state change in any cycle without a grant.
- Credits:
  - Decrement by 1 per grant; increment by 1 per credit_ret; saturate at CREDITS.
  - Grant and credit_ret in the same cycle leave the count unchanged.
  - credit_cnt=0 blocks all grants. credit_ret in the same cycle does not unblock that cycle; granting resumes next cycle.
- Empty flag handling:
  - Empty flags are taken as registered outputs of the queues.
  - The scheduler never asserts fire_en for an empty class.
  - The queue may go empty after a pop; that is seen next cycle.
- sched_en low: fire_en=0; cur, burst and credits hold; credit_ret is still accepted.

Optional Feature:
- Macro: IVPORT_FIRE_SCHED_STATS_EN.
- When defined:
  - Adds three 32-bit outputs: stat_rreq, stat_rresp, stat_wreq.
  - Each counts grants to its class. Counters wrap at 2^32 and reset to 0.
  - Adds output stat_stall (32-bit): counts cycles where slot_avail & sched_en & some queue non-empty & credit_cnt==0.
- When undefined: these ports and registers do not exist; the remaining behaviour is identical.

Test Plan:
- Priority/WRR with all three queues non-empty, slot_avail=1 continuously, CREDITS=8 with credit_ret echoing each out_valid one cycle later -> fire_type_sel sequence 1,1,1,1,0,0,2,2,1,1,...
- Only wreq non-empty with 5 words, slot_avail=1 -> five consecutive grants with sel=2; out_valid high in cycles t+1..t+5 with data in FIFO order; then fire_type_sel=3.
- Credit exhaustion: CREDITS=8, no credit_ret, rresp holds 10 words -> exactly 8 grants and credit_cnt=0. One credit_ret pulse -> exactly one more grant on the following cycle.
- Simultaneous grant and credit_ret while credit_cnt=3 -> credit_cnt stays 3. credit_ret with credit_cnt=8 -> stays 8.
- slot_avail toggling 1,0,1,0 with rreq non-empty -> fire_en only on the slot_avail=1 cycles; burst advances only on grants; out_valid pulses alternate.
- Assert rst low while out_valid=1 mid-burst -> out_valid=0 and fire_type_sel=3 immediately. After release, credit_cnt=8 and arbitration restarts at RRESP.
